// File: rtl/nv_nocif_wr_trk_pkg.sv
// Shared sizing constants and the per-burst tracking entry for the DRAM write-response tracker.
package nv_nocif_wr_trk_pkg;

    localparam int NUM_CLIENTS = 5;
    localparam int FIFO_DEPTH  = 8;
    localparam int CID_W       = $clog2(NUM_CLIENTS);
    localparam int PTR_W       = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic       ack;
        logic [1:0] len;
    } trk_entry_t;

endpackage

// File: rtl/nv_nocif_wr_trk_fifo.sv
// Per-client flop FIFO of tracking entries; pointers carry a wrap bit to tell full from empty.
module nv_nocif_wr_trk_fifo
    import nv_nocif_wr_trk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  trk_entry_t wr_data,
    output logic       full,
    output logic       empty,
    output trk_entry_t head
);

    localparam int AW = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    trk_entry_t       mem_q [FIFO_DEPTH];
    trk_entry_t       mem_d [FIFO_DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is only issued alongside a pop, so the slot written is the
    // one being retired; the popped value was already read from head this cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/nv_nocif_dram_wr_rsp_tracker.sv
// Retires AXI B responses against per-client burst logs, returns credits and bounds outstanding bursts.
// Optional NVDLA_NOCIF_WR_TRK_ERR_EN adds sticky orphan-response flag and saturating orphan counter.
module nv_nocif_dram_wr_rsp_tracker
    import nv_nocif_wr_trk_pkg::*;
(
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic [7:0]             reg2dp_wr_os_cnt,
    input  logic                   trk_wr_pvld,
    output logic                   trk_wr_prdy,
    input  logic [CID_W-1:0]       trk_wr_cid,
    input  logic                   trk_wr_ack,
    input  logic [1:0]             trk_wr_len,
    input  logic                   noc2mcif_axi_b_bvalid,
    output logic                   noc2mcif_axi_b_bready,
    input  logic [7:0]             noc2mcif_axi_b_bid,
    output logic [NUM_CLIENTS-1:0] mcif2client_wr_rsp_complete,
    output logic                   eg2ig_axi_vld,
    output logic [1:0]             eg2ig_axi_len,
    output logic                   os_full
`ifdef NVDLA_NOCIF_WR_TRK_ERR_EN
    ,
    output logic                   trk_err_orphan,
    output logic [7:0]             trk_err_cnt
`endif
);

    logic                   rdy_en_q, rdy_en_d;
    logic [8:0]             os_cnt_q, os_cnt_d;
    logic                   eg_vld_q, eg_vld_d;
    logic [1:0]             eg_len_q, eg_len_d;
    logic [NUM_CLIENTS-1:0] cmpl_q, cmpl_d;

    logic [NUM_CLIENTS-1:0] fifo_full;
    logic [NUM_CLIENTS-1:0] fifo_empty;
    logic [NUM_CLIENTS-1:0] push_vec;
    logic [NUM_CLIENTS-1:0] pop_vec;
    trk_entry_t             fifo_head [NUM_CLIENTS];
    trk_entry_t             wr_entry;
    trk_entry_t             pop_head;
    logic                   b_acc;
    logic                   push_hs;
    logic                   pop_any;
    logic                   cid_blocked;
    logic                   unused_bid_hi;

    assign unused_bid_hi          = ^noc2mcif_axi_b_bid[7:4];
    assign noc2mcif_axi_b_bready  = rdy_en_q;
    assign b_acc                  = noc2mcif_axi_b_bvalid && rdy_en_q;
    assign os_full                = (os_cnt_q >= ({1'b0, reg2dp_wr_os_cnt} + 9'd1));
    assign wr_entry               = '{ack: trk_wr_ack, len: trk_wr_len};
    assign push_hs                = trk_wr_pvld && trk_wr_prdy;
    assign pop_any                = |pop_vec;

    assign mcif2client_wr_rsp_complete = cmpl_q;
    assign eg2ig_axi_vld               = eg_vld_q;
    assign eg2ig_axi_len               = eg_len_q;

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            // Pops decide on the pre-push empty flag, so a same-cycle push is never retired.
            assign pop_vec[gi]  = b_acc && (noc2mcif_axi_b_bid[3:0] == 4'(gi)) && !fifo_empty[gi];
            assign push_vec[gi] = push_hs && (trk_wr_cid == CID_W'(gi));

            nv_nocif_wr_trk_fifo u_fifo (
                .clk     (nvdla_core_clk),
                .rst     (nvdla_core_rst),
                .push    (push_vec[gi]),
                .pop     (pop_vec[gi]),
                .wr_data (wr_entry),
                .full    (fifo_full[gi]),
                .empty   (fifo_empty[gi]),
                .head    (fifo_head[gi])
            );
        end
    endgenerate

    // Client indices beyond NUM_CLIENTS have no FIFO and are never accepted.
    always_comb begin
        cid_blocked = 1'b1;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (trk_wr_cid == CID_W'(c)) begin
                cid_blocked = fifo_full[c] && !pop_vec[c];
            end
        end
        trk_wr_prdy = rdy_en_q && !os_full && !cid_blocked;
    end

    always_comb begin
        pop_head = '0;
        cmpl_d   = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (pop_vec[c]) begin
                pop_head = fifo_head[c];
            end
            cmpl_d[c] = pop_vec[c] && fifo_head[c].ack;
        end
        rdy_en_d = 1'b1;
        eg_vld_d = pop_any;
        eg_len_d = pop_head.len;
        os_cnt_d = os_cnt_q;
        if (push_hs && !pop_any) begin
            os_cnt_d = os_cnt_q + 9'd1;
        end else if (!push_hs && pop_any) begin
            os_cnt_d = os_cnt_q - 9'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rdy_en_q <= 1'b0;
            os_cnt_q <= '0;
            eg_vld_q <= 1'b0;
            eg_len_q <= '0;
            cmpl_q   <= '0;
        end else begin
            rdy_en_q <= rdy_en_d;
            os_cnt_q <= os_cnt_d;
            eg_vld_q <= eg_vld_d;
            eg_len_q <= eg_len_d;
            cmpl_q   <= cmpl_d;
        end
    end

`ifdef NVDLA_NOCIF_WR_TRK_ERR_EN
    logic       orphan;
    logic       err_orphan_q, err_orphan_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign orphan         = b_acc && !pop_any;
    assign trk_err_orphan = err_orphan_q;
    assign trk_err_cnt    = err_cnt_q;

    always_comb begin
        err_orphan_d = err_orphan_q | orphan;
        err_cnt_d    = err_cnt_q;
        if (orphan && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            err_orphan_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_orphan_q <= err_orphan_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
`endif

endmodule
